// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared size codes, FSM encoding and window defaults for data_lsu.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h6600_0000;
    localparam int unsigned DEF_WIN_BYTES = 256;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_FAULT  = 2'd3
    } lsu_state_t;

    // Unsigned load variants exist only for the read direction.
    function automatic logic size_legal(input logic [2:0] size, input logic we);
        case (size)
            LDST_B, LDST_H, LDST_W: return 1'b1;
            LDST_BU, LDST_HU:       return ~we;
            default:                return 1'b0;
        endcase
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Selects the addressed byte/half of a read word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_size,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = i_word;
        case (i_size)
            LDST_B:  o_data = {{24{w_byte[7]}}, w_byte};
            LDST_BU: o_data = {24'h00_0000, w_byte};
            LDST_H:  o_data = {{16{w_half[15]}}, w_half};
            LDST_HU: o_data = {16'h0000, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule : lsu_load_align
`default_nettype wire

// File: rtl/data_lsu.sv
`default_nettype none
// ============================================================================
// Module      : data_lsu
// Description : Single-outstanding load/store unit driving the data-memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module data_lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned WIN_BYTES = DEF_WIN_BYTES
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    localparam logic [31:0] c_win_bytes = 32'(WIN_BYTES);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic [31:0] r_rdata;
    logic [2:0]  r_size;
    logic        r_we;

    logic [31:0] w_offset;
    logic        w_in_window;
    logic        w_aligned;
    logic        w_legal;
    logic        w_accept;
    logic [3:0]  w_be;
    logic [31:0] w_lanes;
    logic [31:0] w_load_data;

    // Unsigned subtraction makes addresses below the base wrap high and fail.
    always_comb begin
        w_offset    = core_addr_i - BASE_ADDR;
        w_in_window = (w_offset < c_win_bytes);
        case (core_size_i[1:0])
            2'b01:   w_aligned = ~core_addr_i[0];
            2'b10:   w_aligned = (core_addr_i[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
        w_legal = w_in_window & w_aligned & size_legal(core_size_i, core_we_i);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (core_req_i) begin
                    if (w_legal) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_ACCESS;
                    end else begin
                        w_state_nxt = ST_FAULT;
                    end
                end
            end
            ST_ACCESS: w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            ST_FAULT:  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr  <= 32'h0;
            r_wd    <= 32'h0;
            r_size  <= 3'b000;
            r_we    <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            if (w_accept) begin
                r_addr <= core_addr_i;
                r_wd   <= core_wd_i;
                r_size <= core_size_i;
                r_we   <= core_we_i;
            end
            if (r_state == ST_ACCESS) begin
                r_rdata <= r_we ? 32'h0 : mem_rd_i;
            end
        end
    end

    // The low two size bits give the access width; bit 2 only matters on the read path.
    always_comb begin
        w_be    = 4'b1111;
        w_lanes = r_wd;
        case (r_size[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_lanes = {4{r_wd[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{r_wd[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_lanes = r_wd;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .i_word    (r_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_size    (r_size),
        .o_data    (w_load_data)
    );

    always_comb begin
        mem_req_o    = (r_state == ST_ACCESS);
        mem_we_o     = mem_req_o & r_we;
        mem_be_o     = mem_req_o ? w_be : 4'b0000;
        mem_wd_o     = mem_we_o ? w_lanes : 32'h0;
        mem_addr_o   = {r_addr[31:2], 2'b00};
        core_fault_o = (r_state == ST_FAULT);
        core_rd_o    = ((r_state == ST_DONE) && !r_we) ? w_load_data : 32'h0;
        core_stall_o = ~rst_i & (((r_state == ST_IDLE) & core_req_i) | (r_state == ST_ACCESS));
    end

endmodule : data_lsu
`default_nettype wire

// File: tb/tb_data_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_lsu
// Description : Directed and randomized self-checking bench for data_lsu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_lsu;

    localparam logic [31:0] c_base = 32'h6600_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_fault_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;

    logic        mem_clear;
    logic [31:0] tb_mem [64];
    logic [7:0]  ref_mem [256];

    int checks = 0;
    int errors = 0;

    data_lsu dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .core_fault_o (core_fault_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i)
    );

    always #5 clk_i = ~clk_i;

    // Word-wide data memory with byte-lane writes.
    assign mem_rd_i = tb_mem[mem_addr_o[7:2]];
    always @(posedge clk_i) begin
        if (mem_clear) begin
            for (int w = 0; w < 64; w++) tb_mem[w] <= 32'h0;
        end else if (mem_req_o && mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) tb_mem[mem_addr_o[7:2]][8*b +: 8] <= mem_wd_o[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        case (sz[1:0])
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic legal_req(input logic we, input logic [2:0] sz, input logic [31:0] addr);
        logic size_ok;
        logic [31:0] off;
        size_ok = we ? (sz <= 3'd2) : (sz <= 3'd2 || sz == 3'd4 || sz == 3'd5);
        off = addr - c_base;
        return size_ok && ((addr % nbytes(sz)) == 0) && (off < 32'd256);
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] sz, input logic [31:0] addr);
        logic [31:0] off;
        longint v;
        int n;
        n = nbytes(sz);
        off = addr - c_base;
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[off[7:0] + i]) << (8 * i);
        if (sz < 3'd4 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // One full core transaction, called just after a falling edge with the LSU idle.
    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd);
        logic        legal;
        logic [31:0] off;
        logic [31:0] exp_rd;
        int          n;
        legal = legal_req(we, sz, addr);
        n = nbytes(sz);
        off = addr - c_base;
        core_req_i = 1'b1; core_we_i = we; core_size_i = sz; core_addr_i = addr; core_wd_i = wd;
        #1;
        chk("req_stall", {31'b0, core_stall_o}, 32'd1);
        chk("req_memreq", {31'b0, mem_req_o}, 32'd0);
        chk("req_fault", {31'b0, core_fault_o}, 32'd0);
        @(posedge clk_i); @(negedge clk_i);
        if (legal) begin
            exp_rd = we ? 32'h0 : exp_load(sz, addr);
            chk("acc_memreq", {31'b0, mem_req_o}, 32'd1);
            chk("acc_we", {31'b0, mem_we_o}, {31'b0, we});
            chk("acc_be", {28'b0, mem_be_o}, ((32'd1 << n) - 32'd1) << (addr % 4));
            chk("acc_addr", mem_addr_o, addr - (addr % 4));
            chk("acc_stall", {31'b0, core_stall_o}, 32'd1);
            if (we) begin
                chk("acc_wd", mem_wd_o, (n == 1) ? {24'h0, wd[7:0]} * 32'h0101_0101 :
                                        (n == 2) ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd);
                for (int i = 0; i < n; i++) ref_mem[off[7:0] + i] = 8'(wd >> (8 * i));
            end
            @(posedge clk_i); @(negedge clk_i);
            chk("done_stall", {31'b0, core_stall_o}, 32'd0);
            chk("done_memreq", {31'b0, mem_req_o}, 32'd0);
            chk("done_be", {28'b0, mem_be_o}, 32'd0);
            chk("done_wd", mem_wd_o, 32'd0);
            chk("done_rd", core_rd_o, exp_rd);
        end else begin
            chk("flt_fault", {31'b0, core_fault_o}, 32'd1);
            chk("flt_stall", {31'b0, core_stall_o}, 32'd0);
            chk("flt_memreq", {31'b0, mem_req_o}, 32'd0);
            chk("flt_rd", core_rd_o, 32'd0);
        end
        core_req_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        chk("idle_fault", {31'b0, core_fault_o}, 32'd0);
        chk("idle_stall", {31'b0, core_stall_o}, 32'd0);
    endtask

    initial begin
        logic [2:0]  sz;
        logic [31:0] addr;
        int          r;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        rst_i = 1'b1; mem_clear = 1'b1;
        core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'b010;
        core_addr_i = c_base; core_wd_i = 32'hFFFF_FFFF;
        @(negedge clk_i); @(negedge clk_i);
        chk("rst_stall", {31'b0, core_stall_o}, 32'd0);
        chk("rst_memreq", {31'b0, mem_req_o}, 32'd0);
        chk("rst_we", {31'b0, mem_we_o}, 32'd0);
        chk("rst_be", {28'b0, mem_be_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wd", mem_wd_o, 32'd0);
        chk("rst_rd", core_rd_o, 32'd0);
        chk("rst_fault", {31'b0, core_fault_o}, 32'd0);
        core_req_i = 1'b0; rst_i = 1'b0; mem_clear = 1'b0;
        @(negedge clk_i);

        // Directed cases.
        access(1'b1, 3'b010, c_base + 32'h10, 32'hDEAD_BEEF);
        access(1'b0, 3'b010, c_base + 32'h10, 32'h0);
        access(1'b1, 3'b000, c_base + 32'h13, 32'h0000_00A5);
        access(1'b0, 3'b000, c_base + 32'h13, 32'h0);
        access(1'b0, 3'b100, c_base + 32'h13, 32'h0);
        access(1'b1, 3'b010, c_base + 32'h10, 32'h8001_7FFF);
        access(1'b0, 3'b001, c_base + 32'h12, 32'h0);
        access(1'b0, 3'b101, c_base + 32'h10, 32'h0);
        access(1'b0, 3'b010, c_base + 32'h02, 32'h0);
        access(1'b0, 3'b001, c_base + 32'h01, 32'h0);
        access(1'b1, 3'b010, c_base + 32'h100, 32'h1234_5678);
        access(1'b0, 3'b010, 32'h65FF_FFFC, 32'h0);
        access(1'b0, 3'b011, c_base + 32'h10, 32'h0);
        access(1'b1, 3'b100, c_base + 32'h10, 32'h0);
        access(1'b1, 3'b001, c_base + 32'hFE, 32'hCAFE_F00D);
        access(1'b0, 3'b001, c_base + 32'hFE, 32'h0);

        // Reset in the middle of a store access.
        access(1'b1, 3'b010, c_base + 32'h24, 32'h0BAD_CAFE);
        core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'b010;
        core_addr_i = c_base + 32'h20; core_wd_i = 32'h5555_AAAA;
        @(posedge clk_i); @(negedge clk_i);
        chk("mid_memreq", {31'b0, mem_req_o}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_memreq", {31'b0, mem_req_o}, 32'd0);
        chk("arst_we", {31'b0, mem_we_o}, 32'd0);
        chk("arst_stall", {31'b0, core_stall_o}, 32'd0);
        chk("arst_addr", mem_addr_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0; core_req_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        chk("post_rst_memreq", {31'b0, mem_req_o}, 32'd0);
        access(1'b0, 3'b010, c_base + 32'h24, 32'h0);

        // Randomized traffic against the byte-level reference memory.
        for (int it = 0; it < 300; it++) begin
            sz = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            if (r < 8)       addr = c_base + $urandom_range(0, 255);
            else if (r == 8) addr = c_base + 32'd256 + $urandom_range(0, 1023);
            else             addr = c_base - 32'd1 - $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) addr = addr & ~(32'(nbytes(sz)) - 32'd1);
            access(1'($urandom_range(0, 1)), sz, addr, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_data_lsu
`default_nettype wire
